fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_pc_reg.sv | 46 ++++
 rtl/fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_fetch_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module : fetch_sequencer_pkg
// Brief  : Shared FSM state type, default reset PC and alignment helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;
  localparam logic [1:0]  c_align_mask       = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & c_align_mask) != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_pc_reg.sv
// ============================================================================
// Module : pc_reg
// Brief  : 32-bit program counter with reset/restart to RESET_PC, load, hold.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_default_reset_pc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart_i,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Restart wins over load; with neither asserted the register holds.
  always_comb begin
    pc_d = pc_q;
    if (restart_i) begin
      pc_d = RESET_PC;
    end else if (load_i) begin
      pc_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module : fetch_sequencer
// Brief  : Issues a bounded run of sequential fetch addresses; faults on a
//          misaligned next address. FETCH_RETIRE_COUNT_EN adds a retired count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_default_reset_pc,
  parameter int          LIMIT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LIMIT_W-1:0] instr_limit,
  input  logic [31:0]        next_addr,
  output logic [31:0]        pc,
  output logic               run,
  output logic               done,
  output logic               fault
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [LIMIT_W-1:0] retired
`endif
);

  state_e             state_q;
  state_e             state_d;
  logic [LIMIT_W-1:0] remaining_q;
  logic [LIMIT_W-1:0] remaining_d;
  logic               pc_restart;
  logic               pc_load;
  logic               start_accept;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    pc_restart   = 1'b0;
    pc_load      = 1'b0;
    start_accept = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_accept = 1'b1;
          pc_restart   = 1'b1;
          if (instr_limit != '0) begin
            state_d     = ST_RUN;
            remaining_d = instr_limit;
          end else begin
            state_d     = ST_DONE;
            remaining_d = '0;
          end
        end
      end
      ST_RUN: begin
        // A misaligned target freezes the PC and beats completion.
        if (is_misaligned(next_addr)) begin
          state_d = ST_FAULT;
        end else begin
          pc_load     = 1'b1;
          remaining_d = remaining_q - LIMIT_W'(1);
          if (remaining_q == LIMIT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .restart_i (pc_restart),
    .load_i    (pc_load),
    .d_i       (next_addr),
    .pc_o      (pc)
  );

  assign run   = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign fault = (state_q == ST_FAULT);

`ifdef FETCH_RETIRE_COUNT_EN
  logic [LIMIT_W-1:0] retired_q;
  logic [LIMIT_W-1:0] retired_d;

  always_comb begin
    retired_d = retired_q;
    if (start_accept) begin
      retired_d = '0;
    end else if (run && (retired_q != '1)) begin
      retired_d = retired_q + LIMIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Scoreboard bench for fetch_sequencer; expected issued PCs are
//          queued by the stimulus and popped by a monitor whenever run is high.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [15:0] lim0 = '0;
  logic [15:0] lim1 = '0;
  logic        bad0 = 1'b0;
  logic [31:0] na0, na1, pc0, pc1;
  logic        run0, run1, done0, done1, fault0, fault1;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [15:0] ret0, ret1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  assign na0 = bad0 ? 32'h0000_0006 : pc0 + 32'd4;
  assign na1 = pc1 + 32'd4;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .LIMIT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .instr_limit(lim0), .next_addr(na0),
    .pc(pc0), .run(run0), .done(done0), .fault(fault0)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retired(ret0)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .LIMIT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .instr_limit(lim1), .next_addr(na1),
    .pc(pc1), .run(run1), .done(done1), .fault(fault1)
`ifdef FETCH_RETIRE_COUNT_EN
    , .retired(ret1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle a DUT presents run=1 its pc must match the queue head.
  always @(negedge clk) begin
    if (run0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0_unexpected_run: got pc %h expected no run", pc0);
      end else begin
        check("dut0_pc", pc0, q0.pop_front());
      end
    end
    if (run1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut1_unexpected_run: got pc %h expected no run", pc1);
      end else begin
        check("dut1_pc", pc1, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(2);
    check("rst_pc0", pc0, 32'h0);
    check("rst_run0", {31'b0, run0}, 32'd0);
    check("rst_done0", {31'b0, done0}, 32'd0);
    check("rst_fault0", {31'b0, fault0}, 32'd0);
    check("rst_pc1", pc1, 32'hFFFF_FFF8);
`ifdef FETCH_RETIRE_COUNT_EN
    check("rst_ret0", {16'b0, ret0}, 32'd0);
`endif
    rst = 1'b0;

    // Three-instruction run with a +4 adder.
    q0.push_back(32'd0); q0.push_back(32'd4); q0.push_back(32'd8);
    start0 = 1'b1; lim0 = 16'd3;
    cyc(1); start0 = 1'b0;
    check("lat_run0", {31'b0, run0}, 32'd1);
    cyc(3);
    check("run3_done", {31'b0, done0}, 32'd1);
    check("run3_pc", pc0, 32'd12);
    check("run3_run", {31'b0, run0}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
    check("run3_ret", {16'b0, ret0}, 32'd3);
`endif

    // Zero-length run from DONE: reload pc, stay DONE, never run.
    start0 = 1'b1; lim0 = 16'd0;
    cyc(1); start0 = 1'b0;
    check("zero_done", {31'b0, done0}, 32'd1);
    check("zero_pc", pc0, 32'd0);
    cyc(1);
    check("zero_run", {31'b0, run0}, 32'd0);

    // Five-instruction run, then a second start restarts the count.
    for (int i = 0; i < 5; i++) q0.push_back(32'(i * 4));
    start0 = 1'b1; lim0 = 16'd5;
    cyc(1); start0 = 1'b0;
    cyc(5);
    check("run5_done", {31'b0, done0}, 32'd1);
    check("run5_pc", pc0, 32'd20);
`ifdef FETCH_RETIRE_COUNT_EN
    check("run5_ret", {16'b0, ret0}, 32'd5);
`endif
    q0.push_back(32'd0); q0.push_back(32'd4);
    start0 = 1'b1; lim0 = 16'd2;
    cyc(1); start0 = 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
    check("restart_ret0", {16'b0, ret0}, 32'd0);
`endif
    cyc(1);
`ifdef FETCH_RETIRE_COUNT_EN
    check("restart_ret1", {16'b0, ret0}, 32'd1);
`endif
    cyc(1);
    check("run2_done", {31'b0, done0}, 32'd1);
    check("run2_pc", pc0, 32'd8);

    // Misaligned next_addr in the second RUN cycle.
    q0.push_back(32'd0); q0.push_back(32'd4);
    start0 = 1'b1; lim0 = 16'd5;
    cyc(1); start0 = 1'b0;
    cyc(1); bad0 = 1'b1;
    cyc(1);
    check("flt_fault", {31'b0, fault0}, 32'd1);
    check("flt_pc", pc0, 32'd4);
    check("flt_done", {31'b0, done0}, 32'd0);
    start0 = 1'b1; lim0 = 16'd3; bad0 = 1'b0;
    cyc(1); start0 = 1'b0;
    cyc(1);
    check("flt_sticky", {31'b0, fault0}, 32'd1);
    check("flt_pc_hold", pc0, 32'd4);
    check("flt_run", {31'b0, run0}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
    check("flt_ret", {16'b0, ret0}, 32'd2);
`endif

    // Fault beats completion on a single-instruction run.
    rst = 1'b1; cyc(1); rst = 1'b0;
    q0.push_back(32'd0);
    start0 = 1'b1; lim0 = 16'd1;
    cyc(1); start0 = 1'b0; bad0 = 1'b1;
    cyc(1); bad0 = 1'b0;
    check("prio_fault", {31'b0, fault0}, 32'd1);
    check("prio_done", {31'b0, done0}, 32'd0);
    check("prio_pc", pc0, 32'd0);

    // Reset in the second RUN cycle of a five-instruction run.
    rst = 1'b1; cyc(1); rst = 1'b0;
    q0.push_back(32'd0); q0.push_back(32'd4);
    start0 = 1'b1; lim0 = 16'd5;
    cyc(1); start0 = 1'b0;
    cyc(1); rst = 1'b1;
    cyc(1); rst = 1'b0;
    check("mrst_pc", pc0, 32'd0);
    check("mrst_run", {31'b0, run0}, 32'd0);
    check("mrst_done", {31'b0, done0}, 32'd0);
    check("mrst_fault", {31'b0, fault0}, 32'd0);
`ifdef FETCH_RETIRE_COUNT_EN
    check("mrst_ret", {16'b0, ret0}, 32'd0);
`endif

    // PC wrap across 2^32 on the high-reset-PC instance.
    q1.push_back(32'hFFFF_FFF8); q1.push_back(32'hFFFF_FFFC);
    q1.push_back(32'h0000_0000); q1.push_back(32'h0000_0004);
    start1 = 1'b1; lim1 = 16'd4;
    cyc(1); start1 = 1'b0;
    cyc(4);
    check("wrap_done", {31'b0, done1}, 32'd1);
    check("wrap_pc", pc1, 32'h0000_0008);
    check("wrap_fault", {31'b0, fault1}, 32'd0);

    cyc(2);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
